// File: rtl/boot_loader.sv
// Bus-ownership sequencer: holds the core in reset, streams a little-endian
// image into memory from word 0, then hands the bus back and releases the core.
module boot_loader #(
   parameter int ADDR_W = 30
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              load_req,
   output logic              cpu_reset,
   input  logic [ADDR_W-1:0] cpu_bus_addr,
   input  logic [31:0]       cpu_bus_data_w,
   input  logic [3:0]        cpu_bus_mask_w,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_data_w,
   output logic [3:0]        mem_mask_w,
   output logic              running,
   output logic [31:0]       checksum
);

   typedef enum logic [2:0] {
      ST_LEN,
      ST_DATA,
      ST_DRAIN,
      ST_RELEASE,
      ST_RUN
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       count_q, count_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [ADDR_W-1:0] word_idx_q, word_idx_d;
   logic [23:0]       asm_q, asm_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic              wr_en_q, wr_en_d;
   logic [31:0]       checksum_q, checksum_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              accept;
   logic              core_owns_bus;

   assign rx_ready      = (state_q == ST_LEN) || (state_q == ST_DATA);
   assign accept        = rx_valid && rx_ready;
   assign core_owns_bus = (state_q == ST_RELEASE) || (state_q == ST_RUN);

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      count_d     = count_q;
      byte_idx_d  = byte_idx_q;
      word_idx_d  = word_idx_q;
      asm_d       = asm_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      wr_en_d     = 1'b0;
      checksum_d  = wr_en_q ? checksum_q + wr_data_q : checksum_q;

      unique case (state_q)
         ST_LEN: begin
            if (accept) begin
               byte_idx_d                   = byte_idx_q + 2'd1;
               count_d[8*byte_idx_q +: 8]   = rx_data;
               if (byte_idx_q == 2'd3) begin
                  state_d = ({rx_data, count_q[23:0]} == 32'd0) ? ST_RELEASE : ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
               byte_idx_d = byte_idx_q + 2'd1;
               unique case (byte_idx_q)
                  2'd0: asm_d[7:0]   = rx_data;
                  2'd1: asm_d[15:8]  = rx_data;
                  2'd2: asm_d[23:16] = rx_data;
                  2'd3: begin
                     wr_en_d    = 1'b1;
                     wr_addr_d  = word_idx_q;
                     wr_data_d  = {rx_data, asm_q};
                     word_idx_d = word_idx_q + 1'b1;
                     count_d    = count_q - 32'd1;
                     if (count_q == 32'd1) state_d = ST_DRAIN;
                  end
               endcase
            end
         end
         ST_DRAIN:   state_d = ST_RELEASE;
         ST_RELEASE: state_d = ST_RUN;
         ST_RUN: begin
            if (load_req) begin
               state_d    = ST_LEN;
               count_d    = '0;
               byte_idx_d = '0;
               word_idx_d = '0;
               checksum_d = '0;
            end
         end
         default: state_d = ST_LEN;
      endcase

      // Registered so the core sees reset drop exactly when RUN begins.
      cpu_reset_d = (state_d != ST_RUN);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from the same pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_LEN;
         count_q     <= '0;
         byte_idx_q  <= '0;
         word_idx_q  <= '0;
         asm_q       <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_en_q     <= 1'b0;
         checksum_q  <= '0;
         cpu_reset_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         byte_idx_q  <= byte_idx_d;
         word_idx_q  <= word_idx_d;
         asm_q       <= asm_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         wr_en_q     <= wr_en_d;
         checksum_q  <= checksum_d;
         cpu_reset_q <= cpu_reset_d;
      end
   end

   assign mem_addr   = core_owns_bus ? cpu_bus_addr   : wr_addr_q;
   assign mem_data_w = core_owns_bus ? cpu_bus_data_w : wr_data_q;
   assign mem_mask_w = core_owns_bus ? cpu_bus_mask_w : (wr_en_q ? 4'hF : 4'h0);

   assign cpu_reset = cpu_reset_q;
   assign running   = (state_q == ST_RUN);
   assign checksum  = checksum_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a default-width instance and a 4-bit-address
// instance share one stream so address wrap can be observed alongside.
module tb_boot_loader;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        load_req;
   logic [29:0] cpu_bus_addr;
   logic [31:0] cpu_bus_data_w;
   logic [3:0]  cpu_bus_mask_w;

   logic        rx_ready_a, cpu_reset_a, running_a;
   logic [29:0] mem_addr_a;
   logic [31:0] mem_data_w_a, checksum_a;
   logic [3:0]  mem_mask_w_a;

   logic        rx_ready_b, cpu_reset_b, running_b;
   logic [3:0]  mem_addr_b;
   logic [31:0] mem_data_w_b, checksum_b;
   logic [3:0]  mem_mask_w_b;

   int  total = 0;
   int  bad   = 0;
   wr_t log_a[$];
   wr_t log_b[$];

   always #5 clock = ~clock;

   boot_loader #(.ADDR_W(30)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready_a),
      .load_req(load_req), .cpu_reset(cpu_reset_a),
      .cpu_bus_addr(cpu_bus_addr), .cpu_bus_data_w(cpu_bus_data_w),
      .cpu_bus_mask_w(cpu_bus_mask_w),
      .mem_addr(mem_addr_a), .mem_data_w(mem_data_w_a), .mem_mask_w(mem_mask_w_a),
      .running(running_a), .checksum(checksum_a)
   );

   boot_loader #(.ADDR_W(4)) u_dut4 (
      .clock(clock), .reset_n(reset_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready_b),
      .load_req(load_req), .cpu_reset(cpu_reset_b),
      .cpu_bus_addr(cpu_bus_addr[3:0]), .cpu_bus_data_w(cpu_bus_data_w),
      .cpu_bus_mask_w(cpu_bus_mask_w),
      .mem_addr(mem_addr_b), .mem_data_w(mem_data_w_b), .mem_mask_w(mem_mask_w_b),
      .running(running_b), .checksum(checksum_b)
   );

   // Loader-side writes only; the core's own traffic in RUN is not logged.
   always @(negedge clock) begin
      if (!running_a && mem_mask_w_a != 4'h0)
         log_a.push_back('{addr: 32'(mem_addr_a), data: mem_data_w_a, mask: mem_mask_w_a});
      if (!running_b && mem_mask_w_b != 4'h0)
         log_b.push_back('{addr: 32'(mem_addr_b), data: mem_data_w_b, mask: mem_mask_w_b});
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            rx_valid = 1'b0;
            step();
         end
      end
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
   endtask

   task automatic pulse_load_req();
      load_req = 1'b1;
      step();
      load_req = 1'b0;
   endtask

   // Sends a 2-word image (0x13, 0x6F) and checks the tail timing and writes.
   task automatic load_two(input string tag, input bit gaps);
      log_a.delete();
      send_word(32'd2, gaps);
      send_word(32'h0000_0013, gaps);
      send_word(32'h0000_006F, gaps);
      load_req = 1'b0;
      check({tag, " drain mask"}, 64'(mem_mask_w_a), 64'hF);
      check({tag, " drain rx_ready"}, 64'(rx_ready_a), 64'd0);
      step();
      check({tag, " release mem_addr"}, 64'(mem_addr_a), 64'd0);
      check({tag, " release mask"}, 64'(mem_mask_w_a), 64'd0);
      check({tag, " release cpu_reset"}, 64'(cpu_reset_a), 64'd1);
      check({tag, " release rx_ready"}, 64'(rx_ready_a), 64'd0);
      step();
      check({tag, " run cpu_reset"}, 64'(cpu_reset_a), 64'd0);
      check({tag, " run running"}, 64'(running_a), 64'd1);
      check({tag, " run rx_ready"}, 64'(rx_ready_a), 64'd0);
      check({tag, " checksum"}, 64'(checksum_a), 64'h82);
      check({tag, " write count"}, 64'(log_a.size()), 64'd2);
      if (log_a.size() == 2) begin
         check({tag, " w0"}, {log_a[0].addr, log_a[0].data}, {32'd0, 32'h13});
         check({tag, " w0 mask"}, 64'(log_a[0].mask), 64'hF);
         check({tag, " w1"}, {log_a[1].addr, log_a[1].data}, {32'd1, 32'h6F});
      end
   endtask

   initial begin
      reset_n        = 1'b0;
      rx_data        = 8'h00;
      rx_valid       = 1'b0;
      load_req       = 1'b0;
      cpu_bus_addr   = '0;
      cpu_bus_data_w = '0;
      cpu_bus_mask_w = '0;
      repeat (2) step();

      check("rst mask", 64'(mem_mask_w_a), 64'd0);
      check("rst addr", 64'(mem_addr_a), 64'd0);
      check("rst data", 64'(mem_data_w_a), 64'd0);
      check("rst rx_ready", 64'(rx_ready_a), 64'd1);
      check("rst running", 64'(running_a), 64'd0);
      check("rst cpu_reset", 64'(cpu_reset_a), 64'd1);
      check("rst checksum", 64'(checksum_a), 64'd0);
      reset_n = 1'b1;
      step();

      load_two("load2", 1'b0);

      // Core traffic passes straight through while running; stream is ignored.
      cpu_bus_addr   = 30'h10;
      cpu_bus_data_w = 32'hAABB_CCDD;
      cpu_bus_mask_w = 4'b0011;
      #1;
      check("pass addr", 64'(mem_addr_a), 64'h10);
      check("pass data", 64'(mem_data_w_a), 64'hAABB_CCDD);
      check("pass mask", 64'(mem_mask_w_a), 64'h3);
      log_a.delete();
      rx_data  = 8'hAA;
      rx_valid = 1'b1;
      repeat (3) step();
      rx_valid = 1'b0;
      check("run ignore rx_ready", 64'(rx_ready_a), 64'd0);
      check("run ignore running", 64'(running_a), 64'd1);
      check("run ignore writes", 64'(log_a.size()), 64'd0);
      cpu_bus_addr   = '0;
      cpu_bus_data_w = '0;
      cpu_bus_mask_w = '0;

      pulse_load_req();
      check("reload cpu_reset", 64'(cpu_reset_a), 64'd1);
      check("reload rx_ready", 64'(rx_ready_a), 64'd1);
      check("reload checksum", 64'(checksum_a), 64'd0);

      // Zero-length image.
      log_a.delete();
      send_word(32'd0, 1'b0);
      check("cnt0 release cpu_reset", 64'(cpu_reset_a), 64'd1);
      check("cnt0 release running", 64'(running_a), 64'd0);
      check("cnt0 release rx_ready", 64'(rx_ready_a), 64'd0);
      step();
      check("cnt0 run cpu_reset", 64'(cpu_reset_a), 64'd0);
      check("cnt0 run running", 64'(running_a), 64'd1);
      check("cnt0 no writes", 64'(log_a.size()), 64'd0);

      // Gapped stream, with load_req held (must be ignored outside RUN).
      pulse_load_req();
      load_req = 1'b1;
      load_two("gap", 1'b1);

      // Reset mid-load: in-flight first-word write is dropped immediately.
      pulse_load_req();
      log_a.delete();
      send_word(32'd3, 1'b0);
      send_word(32'h1111_2222, 1'b0);
      check("abort pre mask", 64'(mem_mask_w_a), 64'hF);
      reset_n = 1'b0;
      #1;
      check("abort mask", 64'(mem_mask_w_a), 64'd0);
      check("abort cpu_reset", 64'(cpu_reset_a), 64'd1);
      check("abort rx_ready", 64'(rx_ready_a), 64'd1);
      step();
      reset_n = 1'b1;
      check("abort no writes", 64'(log_a.size()), 64'd0);
      send_word(32'd1, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      repeat (3) step();
      check("abort reload writes", 64'(log_a.size()), 64'd1);
      if (log_a.size() == 1)
         check("abort reload w0", {log_a[0].addr, log_a[0].data}, {32'd0, 32'hDEAD_BEEF});
      check("abort reload checksum", 64'(checksum_a), 64'hDEAD_BEEF);
      check("abort reload running", 64'(running_a), 64'd1);

      // 17 words of value k: the 4-bit instance wraps word 16 onto address 0.
      pulse_load_req();
      log_a.delete();
      log_b.delete();
      send_word(32'd17, 1'b0);
      for (int k = 0; k < 17; k++) send_word(32'(k), 1'b0);
      repeat (3) step();
      check("wrap running", 64'(running_b), 64'd1);
      check("wrap count a", 64'(log_a.size()), 64'd17);
      check("wrap count b", 64'(log_b.size()), 64'd17);
      if (log_a.size() == 17)
         check("wide w16", {log_a[16].addr, log_a[16].data}, {32'd16, 32'd16});
      if (log_b.size() == 17) begin
         check("wrap w15", {log_b[15].addr, log_b[15].data}, {32'd15, 32'd15});
         check("wrap w16", {log_b[16].addr, log_b[16].data}, {32'd0, 32'd16});
      end
      check("wrap checksum b", 64'(checksum_b), 64'd136);
      check("wrap checksum a", 64'(checksum_a), 64'd136);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
